// File: rtl/lc3b_types.sv
// Shared LC-3b type package: datapath word, byte-enable mask and the
// memory-responder state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    mem_idle    = 2'd0,
    mem_busy    = 2'd1,
    mem_resp_st = 2'd2
  } lc3b_mem_state;

  localparam int LC3B_MEM_MAX_LATENCY = 15;

endpackage : lc3b_types

// File: rtl/lc3b_mem_array.sv
// Word-organised 16-bit storage: one combinational read port, a byte-enabled
// front-door write port and a full-word backdoor write port.
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] i_rd_idx,
  output lc3b_word             o_rd_data,
  input  logic                 i_fd_we,
  input  logic [ADDR_BITS-1:0] i_fd_idx,
  input  lc3b_word             i_fd_wdata,
  input  lc3b_mem_wmask        i_fd_wmask,
  input  logic                 i_bd_we,
  input  logic [ADDR_BITS-1:0] i_bd_idx,
  input  lc3b_word             i_bd_wdata
);

  lc3b_word r_mem [2**ADDR_BITS];

  assign o_rd_data = r_mem[i_rd_idx];

  // NOTE: storage has no reset so preloaded contents survive a CPU reset;
  // the backdoor write is issued first so a same-index front-door byte write,
  // being the later non-blocking update, takes priority.
  always_ff @(posedge clk) begin
    if (i_bd_we) begin
      r_mem[i_bd_idx] <= i_bd_wdata;
    end
    if (i_fd_we && i_fd_wmask[0]) begin
      r_mem[i_fd_idx][7:0] <= i_fd_wdata[7:0];
    end
    if (i_fd_we && i_fd_wmask[1]) begin
      r_mem[i_fd_idx][15:8] <= i_fd_wdata[15:8];
    end
  end

endmodule : lc3b_mem_array

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b mem_read/mem_write/mem_resp handshake:
// one transaction at a time with a fixed response latency.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY   = 3,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  lc3b_word             mem_address,
  input  lc3b_word             mem_wdata,
  input  lc3b_mem_wmask        mem_wmask,
  output logic                 mem_resp,
  output lc3b_word             mem_rdata,
  output logic                 proto_err,
  input  logic                 bd_we,
  input  logic [ADDR_BITS-1:0] bd_addr,
  input  lc3b_word             bd_wdata
);

  localparam logic [3:0] LOAD_COUNT  = 4'(LATENCY - 1);
  localparam bit         DIRECT_RESP = (LATENCY == 1);

  lc3b_mem_state          r_state;
  lc3b_mem_state          w_next_state;
  logic [3:0]             r_count;
  logic [ADDR_BITS-1:0]   r_idx;
  lc3b_word               r_wdata;
  lc3b_mem_wmask          r_wmask;
  logic                   r_is_write;
  lc3b_word               r_rdata;
  logic                   r_proto_err;
  logic                   w_req;
  logic                   w_accept;
  logic                   w_abort;
  logic                   w_fd_we;
  lc3b_word               w_rd_data;
  logic                   w_unused_addr;

  assign w_req         = mem_read | mem_write;
  assign w_unused_addr = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

  // A write asserted in the cycle a reset lands is part of a dropped transaction.
  assign w_fd_we = (r_state == mem_resp_st) && r_is_write && reset_n;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      mem_idle: begin
        if (w_req) begin
          w_accept     = 1'b1;
          w_next_state = DIRECT_RESP ? mem_resp_st : mem_busy;
        end
      end
      mem_busy: begin
        if (!w_req) begin
          w_abort      = 1'b1;
          w_next_state = mem_idle;
        end else if (r_count == 4'd1) begin
          w_next_state = mem_resp_st;
        end
      end
      mem_resp_st: w_next_state = mem_idle;
      default:     w_next_state = mem_idle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= mem_idle;
      r_count     <= '0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_is_write  <= 1'b0;
      r_rdata     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_idx      <= mem_address[ADDR_BITS:1];
        r_wdata    <= mem_wdata;
        r_wmask    <= mem_wmask;
        r_is_write <= mem_write;
        r_count    <= LOAD_COUNT;
        if (mem_read && mem_write) begin
          r_proto_err <= 1'b1;
        end
      end
      if (r_state == mem_busy) begin
        r_count <= r_count - 4'd1;
      end
      if (w_abort) begin
        r_proto_err <= 1'b1;
      end
      if ((r_state == mem_resp_st) && !r_is_write) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  // Read data is visible in the response cycle itself, then held in r_rdata.
  assign mem_resp  = (r_state == mem_resp_st);
  assign mem_rdata = ((r_state == mem_resp_st) && !r_is_write) ? w_rd_data : r_rdata;
  assign proto_err = r_proto_err;

  lc3b_mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk        (clk),
    .i_rd_idx   (r_idx),
    .o_rd_data  (w_rd_data),
    .i_fd_we    (w_fd_we),
    .i_fd_idx   (r_idx),
    .i_fd_wdata (r_wdata),
    .i_fd_wmask (r_wmask),
    .i_bd_we    (bd_we),
    .i_bd_idx   (bd_addr),
    .i_bd_wdata (bd_wdata)
  );

endmodule : lc3b_mem_responder

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder: a LATENCY=3 instance for the main
// handshake cases and a LATENCY=1 instance for the aliasing/short-latency case.
module tb_lc3b_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_wmask;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        proto_err;
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [15:0] bd_wdata;

  logic        mem_read1;
  logic [15:0] mem_address1;
  logic        mem_resp1;
  logic [15:0] mem_rdata1;
  logic        proto_err1;
  logic        bd_we1;
  logic [7:0]  bd_addr1;
  logic [15:0] bd_wdata1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  lc3b_mem_responder #(.LATENCY(3), .ADDR_BITS(8)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata),
    .proto_err   (proto_err),
    .bd_we       (bd_we),
    .bd_addr     (bd_addr),
    .bd_wdata    (bd_wdata)
  );

  lc3b_mem_responder #(.LATENCY(1), .ADDR_BITS(8)) u_dut1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_read    (mem_read1),
    .mem_write   (1'b0),
    .mem_address (mem_address1),
    .mem_wdata   (16'h0000),
    .mem_wmask   (2'b00),
    .mem_resp    (mem_resp1),
    .mem_rdata   (mem_rdata1),
    .proto_err   (proto_err1),
    .bd_we       (bd_we1),
    .bd_addr     (bd_addr1),
    .bd_wdata    (bd_wdata1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic backdoor(input logic [7:0] idx, input logic [15:0] data);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = idx; bd_wdata = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Issues one request; lat is the cycle index of mem_resp counted from the
  // cycle the request is first seen (0), or -1 if it never came.
  task automatic req(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] wd, input logic [1:0] mask,
                     output int lat, output logic [15:0] rdata);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_wmask = mask;
    lat = -1;
    rdata = 16'hxxxx;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mem_resp) begin
        lat = n;
        rdata = mem_rdata;
        break;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("resp_width", {31'd0, mem_resp}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [15:0] d;
    logic [8:0]  resp_hist;
    logic        seen;

    reset_n = 1'b0; mem_read = 0; mem_write = 0; mem_address = 0; mem_wdata = 0;
    mem_wmask = 0; bd_we = 0; bd_addr = 0; bd_wdata = 0;
    mem_read1 = 0; mem_address1 = 0; bd_we1 = 0; bd_addr1 = 0; bd_wdata1 = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_resp", {31'd0, mem_resp}, 32'd0);
    check("reset_rdata", {16'd0, mem_rdata}, 32'h0000);
    check("reset_proto_err", {31'd0, proto_err}, 32'd0);

    // 1: backdoor preload then read with latency 3
    backdoor(8'h10, 16'hBEEF);
    req(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, d);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_rdata", {16'd0, d}, 32'hBEEF);
    check("t1_rdata_held", {16'd0, mem_rdata}, 32'hBEEF);

    // 2: byte-masked writes
    req(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b01, lat, d);
    check("t2_wr_latency", 32'(lat), 32'd3);
    check("t2_rdata_kept_on_write", {16'd0, mem_rdata}, 32'hBEEF);
    req(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, d);
    check("t2_low_byte", {16'd0, d}, 32'hBE34);
    req(1'b0, 1'b1, 16'h0020, 16'h5600, 2'b10, lat, d);
    req(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, d);
    check("t2_high_byte", {16'd0, d}, 32'h5634);
    req(1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, lat, d);
    check("t2_mask00_latency", 32'(lat), 32'd3);
    req(1'b1, 1'b0, 16'h0221, 16'h0000, 2'b00, lat, d);
    check("t2_alias_mask00", {16'd0, d}, 32'h5634);

    // 3: read held through RESP is re-accepted only after the IDLE gap
    @(posedge clk); #1;
    mem_read = 1'b1; mem_address = 16'h0020;
    resp_hist = '0;
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      resp_hist[n] = mem_resp;
      if (n == 7) mem_read = 1'b0;
    end
    check("t3_resp_pattern", {23'd0, resp_hist}, 32'h088);
    check("t3_no_proto_err", {31'd0, proto_err}, 32'd0);

    // 4: write dropped mid-BUSY aborts
    @(posedge clk); #1;
    mem_write = 1'b1; mem_address = 16'h0020; mem_wdata = 16'hFFFF; mem_wmask = 2'b11;
    @(posedge clk); #1;
    mem_write = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      seen = seen | mem_resp;
    end
    check("t4_no_resp", {31'd0, seen}, 32'd0);
    check("t4_proto_err", {31'd0, proto_err}, 32'd1);
    req(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, d);
    check("t4_word_unchanged", {16'd0, d}, 32'h5634);
    check("t4_proto_err_sticky", {31'd0, proto_err}, 32'd1);

    // 5: reset during BUSY of a write
    @(posedge clk); #1;
    mem_write = 1'b1; mem_address = 16'h0020; mem_wdata = 16'h0000; mem_wmask = 2'b11;
    @(posedge clk); #1;
    reset_n = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_resp", {31'd0, mem_resp}, 32'd0);
    check("t5_rdata", {16'd0, mem_rdata}, 32'h0000);
    check("t5_proto_err", {31'd0, proto_err}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    req(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, d);
    check("t5_latency", 32'(lat), 32'd3);
    check("t5_prewrite_value", {16'd0, d}, 32'h5634);

    // simultaneous read+write is flagged and serviced as a write
    req(1'b1, 1'b1, 16'h0022, 16'hA5A5, 2'b11, lat, d);
    check("rw_latency", 32'(lat), 32'd3);
    check("rw_proto_err", {31'd0, proto_err}, 32'd1);
    req(1'b1, 1'b0, 16'h0022, 16'h0000, 2'b00, lat, d);
    check("rw_written", {16'd0, d}, 32'hA5A5);

    // backdoor colliding with a front-door commit loses
    @(posedge clk); #1;
    mem_write = 1'b1; mem_address = 16'h0024; mem_wdata = 16'h1111; mem_wmask = 2'b11;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_resp) begin
        lat = n;
        break;
      end
    end
    check("coll_latency", 32'(lat), 32'd3);
    bd_we = 1'b1; bd_addr = 8'h12; bd_wdata = 16'h2222; mem_write = 1'b0;
    @(posedge clk); #1;
    bd_we = 1'b0;
    req(1'b1, 1'b0, 16'h0024, 16'h0000, 2'b00, lat, d);
    check("coll_front_wins", {16'd0, d}, 32'h1111);

    // 6: LATENCY=1 instance, aliased top address
    @(posedge clk); #1;
    bd_we1 = 1'b1; bd_addr1 = 8'hFF; bd_wdata1 = 16'hCAFE;
    @(posedge clk); #1;
    bd_we1 = 1'b0;
    mem_read1 = 1'b1; mem_address1 = 16'hFFFE;
    lat = -1;
    d = 16'hxxxx;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (mem_resp1) begin
        lat = n;
        d = mem_rdata1;
        break;
      end
    end
    mem_read1 = 1'b0;
    check("t6_latency", 32'(lat), 32'd1);
    check("t6_rdata", {16'd0, d}, 32'hCAFE);
    @(negedge clk);
    check("t6_resp_width", {31'd0, mem_resp1}, 32'd0);
    check("t6_proto_err", {31'd0, proto_err1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_lc3b_mem_responder
